// File: rtl/seq_mult_acc.sv
// Sequential shift-add multiply-accumulate: pout/ovf = a_in*b_in + c_in, 10 cycles of CALC.
// Optional macro SEQ_MULT_ACC_EARLY_EXIT_EN skips CALC when a captured operand is zero.
module seq_mult_acc (
  input  logic       clk,
  input  logic       sclr,
  input  logic [9:0] a_in,
  input  logic [9:0] b_in,
  input  logic [9:0] c_in,
  input  logic       start,
  output logic [9:0] pout,
  output logic       ovf,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CALC = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_nx_s;
  logic [9:0]  a_r, a_nx_s;
  logic [9:0]  b_r, b_nx_s;
  logic [9:0]  c_r, c_nx_s;
  logic [19:0] acc_r, acc_nx_s;
  logic [19:0] mcand_r, mcand_nx_s;
  logic [9:0]  mplier_r, mplier_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic [9:0]  pout_r, pout_nx_s;
  logic        ovf_r, ovf_nx_s;
  logic        busy_r, busy_nx_s;
  logic        valid_r, valid_nx_s;
  logic [19:0] acc_sum_s;

  // Any bit above the 10-bit result field means the result does not fit.
  function automatic logic upper_nonzero(input logic [19:0] v);
    return |v[19:10];
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_nx_s  = state_r;
    a_nx_s      = a_r;
    b_nx_s      = b_r;
    c_nx_s      = c_r;
    acc_nx_s    = acc_r;
    mcand_nx_s  = mcand_r;
    mplier_nx_s = mplier_r;
    cnt_nx_s    = cnt_r;
    pout_nx_s   = pout_r;
    ovf_nx_s    = ovf_r;
    busy_nx_s   = 1'b0;
    valid_nx_s  = 1'b0;
    acc_sum_s   = acc_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = LOAD;
          a_nx_s     = a_in;
          b_nx_s     = b_in;
          c_nx_s     = c_in;
          busy_nx_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end

      LOAD: begin
        acc_nx_s    = {10'd0, c_r};
        mcand_nx_s  = {10'd0, a_r};
        mplier_nx_s = b_r;
        cnt_nx_s    = 4'd0;
`ifdef SEQ_MULT_ACC_EARLY_EXIT_EN
        if ((a_r == 10'd0) || (b_r == 10'd0)) begin
          // Product is zero, so the result is just the addend.
          state_nx_s = DONE;
          pout_nx_s  = c_r;
          ovf_nx_s   = 1'b0;
          valid_nx_s = 1'b1;
        end else begin
          state_nx_s = CALC;
          busy_nx_s  = 1'b1;
        end
`else
        state_nx_s = CALC;
        busy_nx_s  = 1'b1;
`endif
      end

      CALC: begin
        if (mplier_r[0]) begin
          acc_sum_s = acc_r + mcand_r;
        end else begin
          acc_sum_s = acc_r;
        end
        acc_nx_s    = acc_sum_s;
        mcand_nx_s  = {mcand_r[18:0], 1'b0};
        mplier_nx_s = {1'b0, mplier_r[9:1]};
        cnt_nx_s    = cnt_r + 4'd1;
        // Outputs load from the final sum so valid and pout appear together in DONE.
        if (cnt_r == 4'd9) begin
          state_nx_s = DONE;
          pout_nx_s  = acc_sum_s[9:0];
          ovf_nx_s   = upper_nonzero(acc_sum_s);
          valid_nx_s = 1'b1;
        end else begin
          state_nx_s = CALC;
          busy_nx_s  = 1'b1;
        end
      end

      DONE: begin
        state_nx_s = IDLE;
      end

      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; sclr clears everything immediately.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_r  <= IDLE;
      a_r      <= 10'd0;
      b_r      <= 10'd0;
      c_r      <= 10'd0;
      acc_r    <= 20'd0;
      mcand_r  <= 20'd0;
      mplier_r <= 10'd0;
      cnt_r    <= 4'd0;
      pout_r   <= 10'd0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      a_r      <= a_nx_s;
      b_r      <= b_nx_s;
      c_r      <= c_nx_s;
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_nx_s;
      mplier_r <= mplier_nx_s;
      cnt_r    <= cnt_nx_s;
      pout_r   <= pout_nx_s;
      ovf_r    <= ovf_nx_s;
      busy_r   <= busy_nx_s;
      valid_r  <= valid_nx_s;
    end
  end

  assign pout  = pout_r;
  assign ovf   = ovf_r;
  assign busy  = busy_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed table-driven bench for seq_mult_acc plus hand-written multi-cycle sequences.
module tb_seq_mult_acc;

  logic       clk;
  logic       sclr;
  logic [9:0] a_in, b_in, c_in;
  logic       start;
  logic [9:0] pout;
  logic       ovf, busy, valid;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SEQ_MULT_ACC_EARLY_EXIT_EN
  localparam int ZLAT  = 2;
  localparam int ZBUSY = 1;
`else
  localparam int ZLAT  = 12;
  localparam int ZBUSY = 11;
`endif

  seq_mult_acc dut (
    .clk   (clk),
    .sclr  (sclr),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .start (start),
    .pout  (pout),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a, b, c;
    int pout, ovf;
    int lat, busy_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one operation at a negedge and wait (bounded) for its valid pulse.
  task automatic do_op(input int a, input int b, input int c, input int ep, input int eo,
                       input int elat, input int ebusy, input string tag);
    int lat, bcnt, gp, go;
    lat = 0; bcnt = 0; gp = -1; go = -1;
    @(negedge clk);
    a_in = a[9:0]; b_in = b[9:0]; c_in = c[9:0]; start = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (valid) begin
        lat = k; gp = int'(pout); go = int'(ovf);
      end
      start = 1'b0;
      a_in = 10'($urandom); b_in = 10'($urandom); c_in = 10'($urandom);
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_pout"}, gp, ep);
    check({tag, "_ovf"}, go, eo);
    check({tag, "_busy_cycles"}, bcnt, ebusy);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, int'(valid), 0);
    check({tag, "_pout_hold"}, int'(pout), ep);
  endtask

  initial begin
    int vcnt, vlat, vpout, v1, v2, dbl;
    logic prev;

    vecs[0] = '{a:25,   b:40,   c:7,    pout:1007, ovf:0, lat:12,   busy_cyc:11};
    vecs[1] = '{a:1023, b:1023, c:1023, pout:0,    ovf:1, lat:12,   busy_cyc:11};
    vecs[2] = '{a:32,   b:32,   c:0,    pout:0,    ovf:1, lat:12,   busy_cyc:11};
    vecs[3] = '{a:31,   b:33,   c:0,    pout:1023, ovf:0, lat:12,   busy_cyc:11};
    vecs[4] = '{a:0,    b:500,  c:9,    pout:9,    ovf:0, lat:ZLAT, busy_cyc:ZBUSY};
    vecs[5] = '{a:7,    b:0,    c:1000, pout:1000, ovf:0, lat:ZLAT, busy_cyc:ZBUSY};
    vecs[6] = '{a:1,    b:1023, c:1,    pout:0,    ovf:1, lat:12,   busy_cyc:11};
    vecs[7] = '{a:3,    b:5,    c:2,    pout:17,   ovf:0, lat:12,   busy_cyc:11};
    vecs[8] = '{a:100,  b:10,   c:23,   pout:1023, ovf:0, lat:12,   busy_cyc:11};
    vecs[9] = '{a:100,  b:10,   c:24,   pout:0,    ovf:1, lat:12,   busy_cyc:11};

    sclr = 1'b1; start = 1'b0; a_in = 10'd0; b_in = 10'd0; c_in = 10'd0;
    repeat (2) @(negedge clk);
    check("reset_pout", int'(pout), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    sclr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].pout, vecs[i].ovf,
            vecs[i].lat, vecs[i].busy_cyc, $sformatf("vec%0d", i));
    end

    // A second start mid-operation must be ignored.
    vcnt = 0; vlat = 0; vpout = -1;
    @(negedge clk);
    a_in = 10'd25; b_in = 10'd40; c_in = 10'd7; start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++; vlat = k; vpout = int'(pout);
      end
      start = 1'b0;
      if (k == 5) begin
        a_in = 10'd1023; b_in = 10'd1023; c_in = 10'd1023; start = 1'b1;
      end
    end
    check("restart_valid_count", vcnt, 1);
    check("restart_latency", vlat, 12);
    check("restart_pout", vpout, 1007);

    // Reset in the middle of an operation aborts it with no valid pulse.
    @(negedge clk);
    a_in = 10'd1023; b_in = 10'd1023; c_in = 10'd1023; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", int'(busy), 1);
    sclr = 1'b1;
    #1;
    check("abort_pout", int'(pout), 0);
    check("abort_ovf", int'(ovf), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    sclr = 1'b0;
    vcnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("abort_no_valid", vcnt, 0);
    do_op(25, 40, 7, 1007, 0, 12, 11, "after_abort");

    // start held high restarts straight after DONE.
    v1 = 0; v2 = 0; vcnt = 0; dbl = 0; prev = 1'b0;
    @(negedge clk);
    a_in = 10'd3; b_in = 10'd5; c_in = 10'd2; start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (v1 == 0) v1 = k; else v2 = k;
        check($sformatf("held_pout_c%0d", k), int'(pout), 17);
      end
      if (valid && prev) dbl++;
      prev = valid;
    end
    start = 1'b0;
    check("held_valid_count", vcnt, 2);
    check("held_first_lat", v1, 12);
    check("held_second_lat", v2, 25);
    check("held_no_double_valid", dbl, 0);
    repeat (3) @(negedge clk);
    check("held_idle_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_acc.md
SEQ_MULT_ACC -- requirements
Module: seq_mult_acc

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port sclr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port a_in  input  10  unsigned multiplicand (divider quotient side).
REQ-004 SHALL have port b_in  input  10  unsigned multiplier (divisor side).
REQ-005 SHALL have port c_in  input  10  unsigned addend (remainder side).
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port pout  output  10  result a_in*b_in+c_in, low 10 bits.
REQ-008 SHALL have port ovf  output  1  result exceeded 10 bits.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port valid  output  1  one-cycle result-ready pulse.

Function
REQ-011 SHALL reconstruct a divider's dividend from its outputs: result = a_in*b_in + c_in, unsigned.
REQ-012 SHALL implement FSM states IDLE, LOAD, CALC, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL capture a_in, b_in, c_in and go to LOAD; start=0 SHALL stay in IDLE.
REQ-014 LOAD (1 cycle): 20-bit accumulator SHALL be set to zero-extended c_in, 20-bit multiplicand register to zero-extended a_in, 10-bit multiplier register to b_in, 4-bit counter to 0; next state CALC.
REQ-015 CALC: each cycle, if multiplier LSB=1, accumulator SHALL add the multiplicand; multiplicand SHALL shift left 1; multiplier SHALL shift right 1; counter SHALL increment.
REQ-016 CALC SHALL last exactly 10 cycles; on the cycle the counter reaches 9, next state is DONE.
REQ-017 DONE (1 cycle): pout SHALL be loaded with accumulator[9:0] and ovf with OR of accumulator[19:10]; valid=1; next state IDLE.
REQ-018 Accumulator width SHALL be 20 bits; the maximum 1023*1023+1023 = 1047552 fits without wrap.
REQ-019 busy SHALL be 1 in LOAD and CALC, 0 in IDLE and DONE.
REQ-020 Latency: start sampled at edge N -> valid high during cycle after edge N+11, i.e. 12 cycles.
REQ-021 start while not in IDLE SHALL be ignored; no queuing.
REQ-022 start held high continuously SHALL restart on the edge in IDLE that follows DONE.
REQ-023 pout and ovf SHALL hold their values until the next DONE; input changes after capture SHALL have no effect.
REQ-024 valid SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 sclr=1 SHALL immediately force IDLE and clear pout, ovf, busy, valid, the accumulator, operand registers and counter to 0.
REQ-026 sclr asserted mid-operation SHALL abort it with no valid pulse; start SHALL be honoured only at the first edge with sclr=0.

Configuration
REQ-027 Macro SEQ_MULT_ACC_EARLY_EXIT_EN defined: if captured a_in=0 or b_in=0, LOAD SHALL go directly to DONE (result = c_in, ovf=0, latency 2 cycles); otherwise unchanged.
REQ-028 Macro undefined: CALC SHALL always run 10 cycles regardless of operands (fixed latency 12).

Verification
REQ-029 a=25, b=40, c=7, start pulse -> valid after 12 cycles, pout=1007, ovf=0, busy high for exactly 11 cycles.
REQ-030 a=1023, b=1023, c=1023 -> pout=0 (1047552 mod 1024), ovf=1.
REQ-031 a=32, b=32, c=0 -> pout=0, ovf=1; a=31, b=33, c=0 -> pout=1023, ovf=0.
REQ-032 Start pulsed again at cycle 5 of an operation with new operands -> ignored, first result unchanged, a single valid pulse.
REQ-033 sclr asserted at cycle 6 of an operation -> all outputs 0 at once, no valid; new start after release -> correct result 12 cycles later.
REQ-034 a=0, b=500, c=9 -> pout=9, ovf=0; valid at cycle 2 with SEQ_MULT_ACC_EARLY_EXIT_EN defined, at cycle 12 without.
